// File: rtl/mem_store_unit.sv
// Store engine: serialises a committed SB/SH/SW into byte writes on the 8-bit RAM port.
// Optional I/O back-pressure gate enabled by defining MEM_ST_IO_WAIT_EN.
module mem_store_unit #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              st_ena,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [3:0]        st_len,
  output logic              st_done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_DONE,
    S_RELEASE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          k_q, k_d;
  logic                bus_req_q, bus_req_d;
  logic                wr_fire;
  logic                io_hold;
  logic                unused_inputs;
  logic [ADDR_W-1:0]   byte_addr;
  logic [7:0]          byte_data;

  // I/O writes are held off while the UART cannot accept another byte.
`ifdef MEM_ST_IO_WAIT_EN
  assign io_hold       = (addr_q[17:16] == IO_HI) && io_buffer_full;
  assign unused_inputs = ^st_len[3:2];
`else
  assign io_hold       = 1'b0;
  assign unused_inputs = ^{st_len[3:2], io_buffer_full};
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise a
    // path that skips an assignment would infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    last_d    = last_q;
    k_d       = k_q;
    bus_req_d = bus_req_q;
    wr_fire   = 1'b0;

    if (rdy) begin
      unique case (state_q)
        S_IDLE: begin
          if (st_ena) begin
            addr_d    = st_addr;
            data_d    = st_data;
            last_d    = st_len[1:0];
            k_d       = 2'd0;
            bus_req_d = 1'b1;
            state_d   = S_REQ;
          end
        end
        S_REQ: begin
          if (bus_gnt) state_d = S_WRITE;
        end
        S_WRITE: begin
          if (bus_gnt && !io_hold) begin
            wr_fire = 1'b1;
            if (k_q == last_q) begin
              k_d       = 2'd0;
              bus_req_d = 1'b0;
              state_d   = S_DONE;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
        end
        S_DONE: begin
          state_d = S_RELEASE;
        end
        S_RELEASE: begin
          // A still-high st_ena belongs to the store just finished.
          if (!st_ena) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      last_q    <= 2'd0;
      k_q       <= 2'd0;
      bus_req_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, independent of statement order.
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      k_q       <= k_d;
      bus_req_q <= bus_req_d;
    end
  end

  assign byte_addr = addr_q + {{(ADDR_W-2){1'b0}}, k_q};
  assign byte_data = data_q[{k_q, 3'b000} +: 8];

  // Address/data are forced to zero whenever no write is strobed.
  assign mem_wr   = wr_fire;
  assign mem_a    = wr_fire ? byte_addr : '0;
  assign mem_dout = wr_fire ? byte_data : 8'h00;
  assign bus_req  = bus_req_q;
  assign st_done  = rdy && (state_q == S_DONE);

  a_wr_needs_req: assert property (@(posedge clk) disable iff (rst) mem_wr |-> bus_req);
  a_done_single:  assert property (@(posedge clk) disable iff (rst) st_done |=> !st_done);

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed self-checking bench for mem_store_unit; honours MEM_ST_IO_WAIT_EN if defined.
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        st_ena = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_len = '0;
  logic        st_done;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [39:0] wr_log[$];
  logic [39:0] exp_log[$];

  mem_store_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .st_ena(st_ena), .st_addr(st_addr), .st_data(st_data), .st_len(st_len),
    .st_done(st_done), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Every strobed byte, captured mid-cycle.
  always @(negedge clk) if (mem_wr === 1'b1) wr_log.push_back({mem_a, mem_dout});

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_quiet(input string tag, input logic exp_req);
    check({tag, " mem_wr"}, 40'(mem_wr), 40'd0);
    check({tag, " st_done"}, 40'(st_done), 40'd0);
    check({tag, " bus_req"}, 40'(bus_req), 40'(exp_req));
  endtask

  task automatic check_byte(input string tag, input logic [31:0] a, input logic [7:0] d);
    check({tag, " mem_wr"}, 40'(mem_wr), 40'd1);
    check({tag, " mem_a"}, 40'(mem_a), 40'(a));
    check({tag, " mem_dout"}, 40'(mem_dout), 40'(d));
    check({tag, " st_done"}, 40'(st_done), 40'd0);
    exp_log.push_back({a, d});
  endtask

  task automatic check_done(input string tag);
    check({tag, " st_done"}, 40'(st_done), 40'd1);
    check({tag, " done mem_wr"}, 40'(mem_wr), 40'd0);
    check({tag, " done bus_req"}, 40'(bus_req), 40'd0);
  endtask

  task automatic compare_log(input string tag);
    check({tag, " write count"}, 40'(wr_log.size()), 40'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++)
      if (i < wr_log.size()) check({tag, " write entry"}, wr_log[i], exp_log[i]);
    wr_log.delete();
    exp_log.delete();
  endtask

  // Cycle 0: present the request while the engine is idle.
  task automatic start(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] len);
    next_cycle();
    st_ena = 1'b1; st_addr = a; st_data = d; st_len = len;
    #1;
    check_quiet({tag, " c0"}, 1'b0);
  endtask

  // Whole store with grant held high; requester drops ena the cycle after done.
  task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] len, input int nbytes);
    logic [31:0] dv;
    dv = d;
    bus_gnt = 1'b1;
    start(tag, a, d, len);
    next_cycle(); #1;
    check_quiet({tag, " c1"}, 1'b1);
    for (int k = 0; k < nbytes; k++) begin
      next_cycle(); #1;
      check_byte(tag, a + 32'(k), dv[8*k +: 8]);
    end
    next_cycle(); #1;
    check_done(tag);
    next_cycle();
    st_ena = 1'b0;
    #1;
    check_quiet({tag, " release"}, 1'b0);
    compare_log(tag);
  endtask

  initial begin
    logic [31:0] d3;

    // Reset state, observed without a clock edge.
    #1 rst = 1'b1;
    #1;
    check_quiet("reset", 1'b0);
    check("reset mem_a", 40'(mem_a), 40'd0);
    check("reset mem_dout", 40'(mem_dout), 40'd0);
    next_cycle();
    rst = 1'b0;

    // SW: bytes on cycles 2-5, done on cycle 6.
    run_store("sw", 32'h0000_1000, 32'hDEAD_BEEF, 4'd3, 4);

    // SB followed immediately by SH; no repeat of the SB write.
    run_store("sb", 32'h0000_0020, 32'h0000_0055, 4'd0, 1);
    run_store("sh", 32'h0000_0022, 32'h0000_A1B2, 4'd1, 2);

    // Upper st_len bits ignored: 4'b1110 means 3 bytes.
    run_store("len3", 32'h0000_0080, 32'h00CC_BBAA, 4'b1110, 3);

    // Grant loss and stall in the middle of a SW.
    d3 = 32'h4433_2211;
    bus_gnt = 1'b1;
    start("dist", 32'h40, d3, 4'd3);
    next_cycle(); #1;
    check_quiet("dist c1", 1'b1);
    next_cycle(); #1; check_byte("dist b0", 32'h40, 8'h11);
    next_cycle(); #1; check_byte("dist b1", 32'h41, 8'h22);
    next_cycle(); bus_gnt = 1'b0; #1; check_quiet("dist gnt0 a", 1'b1);
    next_cycle(); #1; check_quiet("dist gnt0 b", 1'b1);
    next_cycle(); bus_gnt = 1'b1; rdy = 1'b0; #1; check_quiet("dist stall", 1'b1);
    next_cycle(); rdy = 1'b1; #1; check_byte("dist b2", 32'h42, 8'h33);
    next_cycle(); #1; check_byte("dist b3", 32'h43, 8'h44);
    next_cycle(); #1; check_done("dist");
    next_cycle(); st_ena = 1'b0; #1; check_quiet("dist release", 1'b0);
    compare_log("dist");

    // Address wrap, late grant, stalled done pulse.
    bus_gnt = 1'b0;
    start("wrap", 32'hFFFF_FFFF, 32'h0000_1234, 4'd1);
    next_cycle(); #1; check_quiet("wrap req a", 1'b1);
    next_cycle(); #1; check_quiet("wrap req b", 1'b1);
    next_cycle(); bus_gnt = 1'b1; #1; check_quiet("wrap req c", 1'b1);
    next_cycle(); #1; check_byte("wrap b0", 32'hFFFF_FFFF, 8'h34);
    next_cycle(); #1; check_byte("wrap b1", 32'h0000_0000, 8'h12);
    next_cycle(); rdy = 1'b0; #1; check_quiet("wrap done stall", 1'b0);
    next_cycle(); rdy = 1'b1; #1; check_done("wrap");
    next_cycle(); st_ena = 1'b0; #1; check_quiet("wrap release", 1'b0);
    compare_log("wrap");

    // I/O region SB with the UART buffer full for three WRITE cycles.
    bus_gnt = 1'b1;
    start("io", 32'h0003_0000, 32'h0000_005A, 4'd0);
    next_cycle(); #1; check_quiet("io c1", 1'b1);
`ifdef MEM_ST_IO_WAIT_EN
    io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1; check_quiet("io held", 1'b1);
    end
    next_cycle(); io_buffer_full = 1'b0; #1; check_byte("io b0", 32'h0003_0000, 8'h5A);
`else
    next_cycle(); io_buffer_full = 1'b1; #1; check_byte("io b0", 32'h0003_0000, 8'h5A);
    io_buffer_full = 1'b0;
`endif
    next_cycle(); #1; check_done("io");
    next_cycle(); st_ena = 1'b0; #1; check_quiet("io release", 1'b0);
    compare_log("io");

    // Asynchronous reset after two bytes of a SW.
    bus_gnt = 1'b1;
    start("rst", 32'h0000_0100, 32'h8765_4321, 4'd3);
    next_cycle(); #1; check_quiet("rst c1", 1'b1);
    next_cycle(); #1; check_byte("rst b0", 32'h100, 8'h21);
    next_cycle(); #1; check_byte("rst b1", 32'h101, 8'h43);
    next_cycle(); #1;
    check("rst b2 pending", 40'(mem_wr), 40'd1);
    rst = 1'b1; st_ena = 1'b0;
    #1;
    check_quiet("rst async", 1'b0);
    check("rst async mem_a", 40'(mem_a), 40'd0);
    check("rst async mem_dout", 40'(mem_dout), 40'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1; check_quiet("rst idle", 1'b0);
    end
    compare_log("rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
